// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: instruction word
// bit positions, the quiescent (IDLE) instruction word and the FSM states.
package core_inst_pkg;

    localparam int unsigned INST_W       = 35;

    localparam int unsigned ACC_BIT      = 33;
    localparam int unsigned CEN_PMEM_BIT = 32;
    localparam int unsigned WEN_PMEM_BIT = 31;
    localparam int unsigned A_PMEM_LSB   = 20;
    localparam int unsigned CEN_XMEM_BIT = 19;
    localparam int unsigned WEN_XMEM_BIT = 18;
    localparam int unsigned A_XMEM_LSB   = 7;
    localparam int unsigned OFIFO_RD_BIT = 6;
    localparam int unsigned L0_RD_BIT    = 3;
    localparam int unsigned L0_WR_BIT    = 2;
    localparam int unsigned EXECUTE_BIT  = 1;
    localparam int unsigned LOAD_BIT     = 0;

    // Both SRAMs disabled (CEN=1) and not writing (WEN=1), everything else 0.
    localparam logic [INST_W-1:0] IDLE_WORD = 35'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WFETCH = 3'd1,
        S_KLOAD  = 3'd2,
        S_KWAIT  = 3'd3,
        S_AFETCH = 3'd4,
        S_EXEC   = 3'd5,
        S_OWRITE = 3'd6,
        S_DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/sram_stream_rd.sv
// Streams num consecutive xmem reads starting at base and produces the
// matching L0 write strobe one cycle later (xmem read latency is 1 cycle).
// Runs for num+1 cycles while en is held; last flags the final cycle.
module sram_stream_rd #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] num,
    output logic          rd,
    output logic [AW-1:0] addr,
    output logic          wr,
    output logic          last
);

    logic [AW-1:0] cnt;
    logic          wr_q;

    // Read index and the read-issued flag that becomes the L0 write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            wr_q <= 1'b0;
        end else begin
            cnt  <= (en && !last) ? cnt + 1'b1 : '0;
            wr_q <= rd;
        end
    end

    // Read request, wrapping address and the delayed write strobe.
    always_comb begin
        rd   = en && (cnt < num);
        addr = base + cnt;
        wr   = en && wr_q;
        last = en && (cnt == num);
    end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer for core: runs one weight-stationary tile per start
// pulse (kernel fetch/load, drain wait, activation fetch/execute, psum
// write-back) and drives the registered 35-bit inst word.
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int KDRAIN = row + col,
    parameter int AW     = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     cfg_wbase,
    input  logic [AW-1:0]     cfg_abase,
    input  logic [AW-1:0]     cfg_pbase,
    input  logic [AW-1:0]     cfg_len,
    input  logic              cfg_acc,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nx;
    logic [AW-1:0]     cnt, cnt_nx;
    logic              cnt_inc;
    logic [AW-1:0]     wbase_q, abase_q, pbase_q, len_q;
    logic              acc_q;
    logic [INST_W-1:0] inst_nx;

    logic              st_en, st_rd, st_wr, st_last;
    logic [AW-1:0]     st_base, st_num, st_addr;

    // One streamer serves both the kernel and the activation fetch phases.
    always_comb begin
        st_en   = (state == S_WFETCH) || (state == S_AFETCH);
        st_base = (state == S_AFETCH) ? abase_q : wbase_q;
        st_num  = (state == S_AFETCH) ? len_q : AW'(col);
    end

    sram_stream_rd #(.AW(AW)) u_stream (
        .clk   (clk),
        .reset (reset),
        .en    (st_en),
        .base  (st_base),
        .num   (st_num),
        .rd    (st_rd),
        .addr  (st_addr),
        .wr    (st_wr),
        .last  (st_last)
    );

    // Next-state and phase counter; the counter restarts on every state change.
    always_comb begin
        state_nx = state;
        cnt_inc  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_WFETCH;
            S_WFETCH: if (st_last) state_nx = S_KLOAD;
            S_KLOAD: begin
                cnt_inc = 1'b1;
                if (cnt == AW'(col - 1)) state_nx = S_KWAIT;
            end
            S_KWAIT: begin
                cnt_inc = 1'b1;
                if (cnt == AW'(KDRAIN - 1))
                    state_nx = (len_q == '0) ? S_DONE : S_AFETCH;
            end
            S_AFETCH: if (st_last) state_nx = S_EXEC;
            S_EXEC: begin
                cnt_inc = 1'b1;
                if (cnt == len_q - 1'b1) state_nx = S_OWRITE;
            end
            S_OWRITE: begin
                if (ofifo_valid) begin
                    cnt_inc = 1'b1;
                    if (cnt == len_q - 1'b1) state_nx = S_DONE;
                end
            end
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        cnt_nx = (state_nx != state) ? '0 : cnt + {{(AW-1){1'b0}}, cnt_inc};
    end

    // Instruction word for the current state, registered on the next edge.
    always_comb begin
        inst_nx = IDLE_WORD;
        case (state)
            S_WFETCH, S_AFETCH: begin
                if (st_rd) begin
                    inst_nx[CEN_XMEM_BIT]         = 1'b0;
                    inst_nx[A_XMEM_LSB +: AW]     = st_addr;
                end
                if (st_wr) inst_nx[L0_WR_BIT] = 1'b1;
            end
            S_KLOAD: begin
                inst_nx[LOAD_BIT]  = 1'b1;
                inst_nx[L0_RD_BIT] = 1'b1;
            end
            S_EXEC: begin
                inst_nx[EXECUTE_BIT] = 1'b1;
                inst_nx[L0_RD_BIT]   = 1'b1;
                inst_nx[ACC_BIT]     = acc_q;
            end
            S_OWRITE: begin
                if (ofifo_valid) begin
                    inst_nx[OFIFO_RD_BIT]         = 1'b1;
                    inst_nx[CEN_PMEM_BIT]         = 1'b0;
                    inst_nx[WEN_PMEM_BIT]         = 1'b0;
                    inst_nx[A_PMEM_LSB +: AW]     = pbase_q + cnt;
                end
            end
            default: inst_nx = IDLE_WORD;
        endcase
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            inst    <= IDLE_WORD;
            busy    <= 1'b0;
            done    <= 1'b0;
            wbase_q <= '0;
            abase_q <= '0;
            pbase_q <= '0;
            len_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            inst  <= inst_nx;
            done  <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                busy    <= 1'b1;
                wbase_q <= cfg_wbase;
                abase_q <= cfg_abase;
                pbase_q <= cfg_pbase;
                len_q   <= cfg_len;
                acc_q   <= cfg_acc;
            end else if (state == S_DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed testbench for core_inst_seq: builds the expected per-cycle
// instruction stream of a tile from its phase description and compares
// inst/busy/done every cycle.
module tb_core_inst_seq;

    localparam int          COL    = 8;
    localparam int          KDRAIN = 16;
    localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] cfg_wbase;
    logic [10:0] cfg_abase;
    logic [10:0] cfg_pbase;
    logic [10:0] cfg_len;
    logic        cfg_acc;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    core_inst_seq #(.row(8), .col(COL), .KDRAIN(KDRAIN), .AW(11)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_wbase   (cfg_wbase),
        .cfg_abase   (cfg_abase),
        .cfg_pbase   (cfg_pbase),
        .cfg_len     (cfg_len),
        .cfg_acc     (cfg_acc),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks that the DUT sits idle for n cycles.
    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s inst c%0d", tag, i), inst, IDLE_W);
            check($sformatf("%s busy c%0d", tag, i), {34'b0, busy}, 35'd0);
            check($sformatf("%s done c%0d", tag, i), {34'b0, done}, 35'd0);
        end
    endtask

    // Runs one tile. pat gives ofifo_valid per OWRITE cycle (bit k for the
    // k-th cycle, 1 beyond pat_len). At slot dist_slot start is pulsed again
    // with different cfg values, which must be ignored.
    task automatic run_tile(input int id, input logic [10:0] wb, input logic [10:0] ab,
                            input logic [10:0] pb, input logic [10:0] ln, input logic acc,
                            input logic [7:0] pat, input int pat_len, input int dist_slot);
        logic [34:0] ew[$];
        logic        ev[$];
        logic        eb[$];
        logic        ed[$];
        logic [34:0] w;
        logic        v;
        int          j;
        int          k;

        for (int i = 0; i <= COL; i++) begin
            w = IDLE_W;
            if (i < COL) begin w[19] = 1'b0; w[17:7] = wb + 11'(i); end
            if (i >= 1) w[2] = 1'b1;
            ew.push_back(w); ev.push_back(1'b1); eb.push_back(1'b1); ed.push_back(1'b0);
        end
        for (int i = 0; i < COL; i++) begin
            w = IDLE_W; w[0] = 1'b1; w[3] = 1'b1;
            ew.push_back(w); ev.push_back(1'b1); eb.push_back(1'b1); ed.push_back(1'b0);
        end
        for (int i = 0; i < KDRAIN; i++) begin
            ew.push_back(IDLE_W); ev.push_back(1'b1); eb.push_back(1'b1); ed.push_back(1'b0);
        end
        if (ln != 11'd0) begin
            for (int i = 0; i <= int'(ln); i++) begin
                w = IDLE_W;
                if (i < int'(ln)) begin w[19] = 1'b0; w[17:7] = ab + 11'(i); end
                if (i >= 1) w[2] = 1'b1;
                ew.push_back(w); ev.push_back(1'b1); eb.push_back(1'b1); ed.push_back(1'b0);
            end
            for (int i = 0; i < int'(ln); i++) begin
                w = IDLE_W; w[1] = 1'b1; w[3] = 1'b1; w[33] = acc;
                ew.push_back(w); ev.push_back(1'b1); eb.push_back(1'b1); ed.push_back(1'b0);
            end
            j = 0;
            k = 0;
            while (j < int'(ln)) begin
                v = (k < pat_len) ? pat[k] : 1'b1;
                w = IDLE_W;
                if (v) begin
                    w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = pb + 11'(j);
                    j++;
                end
                ew.push_back(w); ev.push_back(v); eb.push_back(1'b1); ed.push_back(1'b0);
                k++;
            end
        end
        // DONE slot, then back in IDLE
        ew.push_back(IDLE_W); ev.push_back(1'b1); eb.push_back(1'b0); ed.push_back(1'b1);
        ew.push_back(IDLE_W); ev.push_back(1'b1); eb.push_back(1'b0); ed.push_back(1'b0);

        cfg_wbase = wb; cfg_abase = ab; cfg_pbase = pb; cfg_len = ln; cfg_acc = acc;
        start = 1'b1;
        @(posedge clk); #1;
        check($sformatf("t%0d accept busy", id), {34'b0, busy}, 35'd1);
        check($sformatf("t%0d accept done", id), {34'b0, done}, 35'd0);
        check($sformatf("t%0d accept inst", id), inst, IDLE_W);
        start = 1'b0;
        ofifo_valid = ev[0];
        for (int n = 0; n < ew.size(); n++) begin
            if (n == dist_slot) begin
                start = 1'b1;
                cfg_wbase = ~wb; cfg_abase = ~ab; cfg_pbase = ~pb;
                cfg_len = ln + 11'd3; cfg_acc = ~acc;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            check($sformatf("t%0d slot%0d inst", id, n), inst, ew[n]);
            check($sformatf("t%0d slot%0d busy", id, n), {34'b0, busy}, {34'b0, eb[n]});
            check($sformatf("t%0d slot%0d done", id, n), {34'b0, done}, {34'b0, ed[n]});
            ofifo_valid = (n + 1 < ew.size()) ? ev[n + 1] : 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        cfg_wbase = '0; cfg_abase = '0; cfg_pbase = '0; cfg_len = '0; cfg_acc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        idle_cycles("reset_idle", 10);

        // Basic tile, ofifo_valid held high.
        run_tile(1, 11'd0, 11'd16, 11'd0, 11'd4, 1'b1, 8'hFF, 0, -1);

        // OWRITE stalls: valid pattern 1,0,0,1,1,0,1.
        run_tile(2, 11'd3, 11'd100, 11'd50, 11'd4, 1'b0, 8'h59, 7, -1);

        // Address wrap on all three SRAM address fields.
        run_tile(3, 11'd2044, 11'd2046, 11'd2046, 11'd4, 1'b1, 8'hFF, 0, -1);

        // len = 0: straight from KWAIT to DONE.
        run_tile(4, 11'd5, 11'd9, 11'd7, 11'd0, 1'b0, 8'hFF, 0, -1);

        // Reset during EXEC, with start coincident with reset.
        cfg_wbase = 11'd0; cfg_abase = 11'd16; cfg_pbase = 11'd0; cfg_len = 11'd4; cfg_acc = 1'b1;
        ofifo_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("rst first exec inst", inst, 35'h3_800C_000A);
        check("rst first exec busy", {34'b0, busy}, 35'd1);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check("rst inst", inst, IDLE_W);
        check("rst busy", {34'b0, busy}, 35'd0);
        check("rst done", {34'b0, done}, 35'd0);
        reset = 1'b0;
        start = 1'b0;
        idle_cycles("post_rst", 4);

        // start pulsed while busy with different cfg: ignored, no queueing.
        run_tile(5, 11'd10, 11'd20, 11'd30, 11'd3, 1'b1, 8'hFF, 0, 5);
        idle_cycles("after_busy_start", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
